rvfi_retire_serializer: RTL and testbench

- Upstream feeder for the single-channel data-memory consistency checker.
- Takes an NRET-wide RVFI retirement bus (memory-relevant fields plus order) and emits the retirements one per cycle, in retirement order, on a single registered RVFI channel.
- Buffers bursts in a circular FIFO.
- Flags two conditions with sticky error bits: FIFO overflow, and gaps or reorders in rvfi_order.

---
 rtl/rvfi_retire_serializer.sv | 172 +++++++++++++++++
 tb/tb_rvfi_retire_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_retire_serializer
// Description : Serializes an NRET-wide RVFI retirement bus into one registered
//               channel through a circular FIFO; sticky overflow/order errors.
//               Order tracker built only with RVFI_SERIALIZER_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_retire_serializer #(
    parameter int XLEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NRET-1:0]              in_valid,
    input  logic [NRET*64-1:0]           in_order,
    input  logic [NRET*XLEN-1:0]         in_mem_addr,
    input  logic [NRET*XLEN/8-1:0]       in_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]       in_mem_wmask,
    input  logic [NRET*XLEN-1:0]         in_mem_rdata,
    input  logic [NRET*XLEN-1:0]         in_mem_wdata,
    output logic                         out_valid,
    output logic [63:0]                  out_order,
    output logic [XLEN-1:0]              out_mem_addr,
    output logic [XLEN/8-1:0]            out_mem_rmask,
    output logic [XLEN/8-1:0]            out_mem_wmask,
    output logic [XLEN-1:0]              out_mem_rdata,
    output logic [XLEN-1:0]              out_mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         order_err
);

    localparam int c_MW      = XLEN / 8;
    localparam int c_LW      = $clog2(DEPTH + 1);
    localparam int c_PW      = $clog2(DEPTH);
    localparam int c_EW      = 64 + 3 * XLEN + 2 * c_MW;
    localparam logic [c_LW-1:0] c_DEPTH_L = c_LW'(DEPTH);

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_EW-1:0] w_entry [NRET];
    logic [63:0]     w_order [NRET];

    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_overflow;
    logic            r_out_valid;
    logic [c_EW-1:0] r_out_entry;

    logic            w_pop;
    logic [c_LW-1:0] w_free;
    logic [c_LW-1:0] w_cnt;
    logic            w_drop;
    logic [NRET-1:0] w_accept;
    logic [c_PW-1:0] w_slot [NRET];

    generate
        for (genvar g = 0; g < NRET; g++) begin : g_pack
            assign w_order[g] = in_order[g*64 +: 64];
            assign w_entry[g] = {in_order[g*64 +: 64],
                                 in_mem_addr[g*XLEN +: XLEN],
                                 in_mem_rmask[g*c_MW +: c_MW],
                                 in_mem_wmask[g*c_MW +: c_MW],
                                 in_mem_rdata[g*XLEN +: XLEN],
                                 in_mem_wdata[g*XLEN +: XLEN]};
        end
    endgenerate

    // Compact valid channels oldest-first into the free slots; a popping
    // head frees its slot in the same cycle.
    always_comb begin
        w_pop    = (r_level != '0);
        w_free   = c_DEPTH_L - r_level + {{(c_LW-1){1'b0}}, w_pop};
        w_cnt    = '0;
        w_drop   = 1'b0;
        w_accept = '0;
        for (int i = 0; i < NRET; i++) begin
            w_slot[i] = '0;
            if (in_valid[i]) begin
                if (w_cnt < w_free) begin
                    w_accept[i] = 1'b1;
                    w_slot[i]   = r_wr_ptr + w_cnt[c_PW-1:0];
                    w_cnt       = w_cnt + c_LW'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (w_accept[i]) begin
                r_mem[w_slot[i]] <= w_entry[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_cnt[c_PW-1:0];
            r_level    <= r_level + w_cnt - {{(c_LW-1){1'b0}}, w_pop};
            r_overflow <= r_overflow | w_drop;
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_entry <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + c_PW'(1);
            end else begin
                r_out_valid <= 1'b0;
                r_out_entry <= '0;
            end
        end
    end

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    logic        r_armed;
    logic [63:0] r_expect;
    logic        r_order_err;
    logic        w_armed;
    logic [63:0] w_expect;
    logic        w_oerr;

    // Walk accepted entries in compaction order; every entry resyncs expect.
    always_comb begin
        w_armed  = r_armed;
        w_expect = r_expect;
        w_oerr   = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (w_accept[i]) begin
                if (w_armed && (w_order[i] != w_expect)) begin
                    w_oerr = 1'b1;
                end
                w_armed  = 1'b1;
                w_expect = w_order[i] + 64'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_expect    <= '0;
            r_order_err <= 1'b0;
        end else begin
            r_armed     <= w_armed;
            r_expect    <= w_expect;
            r_order_err <= r_order_err | w_oerr;
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign {out_order, out_mem_addr, out_mem_rmask, out_mem_wmask,
            out_mem_rdata, out_mem_wdata} = r_out_entry;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_retire_serializer
// Description : Scoreboard bench for rvfi_retire_serializer (XLEN=32, NRET=2,
//               DEPTH=8); honours RVFI_SERIALIZER_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_serializer;

    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [63:0] order;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } ent_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [NRET-1:0]    in_valid = '0;
    logic [NRET*64-1:0] in_order = '0;
    logic [NRET*32-1:0] in_mem_addr = '0;
    logic [NRET*4-1:0]  in_mem_rmask = '0;
    logic [NRET*4-1:0]  in_mem_wmask = '0;
    logic [NRET*32-1:0] in_mem_rdata = '0;
    logic [NRET*32-1:0] in_mem_wdata = '0;
    logic               out_valid;
    logic [63:0]        out_order;
    logic [31:0]        out_mem_addr;
    logic [3:0]         out_mem_rmask;
    logic [3:0]         out_mem_wmask;
    logic [31:0]        out_mem_rdata;
    logic [31:0]        out_mem_wdata;
    logic [3:0]         level;
    logic               overflow;
    logic               order_err;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_oerr = 1'b0;
    logic        m_armed = 1'b0;
    logic [63:0] m_expect = '0;

    rvfi_retire_serializer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_order(in_order), .in_mem_addr(in_mem_addr),
        .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
        .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata),
        .out_valid(out_valid), .out_order(out_order), .out_mem_addr(out_mem_addr),
        .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask),
        .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
        .level(level), .overflow(overflow), .order_err(order_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] o);
        ent_t e;
        e.order = o;
        e.addr  = o[31:0] * 32'd4 + 32'h1000;
        e.rmask = o[3:0];
        e.wmask = o[7:4] ^ 4'hA;
        e.rdata = o[31:0] ^ 32'hDEADBEEF;
        e.wdata = ~o[31:0];
        return e;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_ovf    = 1'b0;
        m_oerr   = 1'b0;
        m_armed  = 1'b0;
        m_expect = '0;
    endtask

    // One clock cycle: drive at the falling edge, advance the model, check after the rise.
    task automatic step(input logic rst_v, input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
        ent_t e[2];
        ent_t exp_e;
        logic exp_v;
        @(negedge clock);
        e[0] = mk(o0);
        e[1] = mk(o1);
        reset_n  = rst_v;
        in_valid = v;
        for (int i = 0; i < 2; i++) begin
            if (v[i]) begin
                in_order[i*64 +: 64]     = e[i].order;
                in_mem_addr[i*32 +: 32]  = e[i].addr;
                in_mem_rmask[i*4 +: 4]   = e[i].rmask;
                in_mem_wmask[i*4 +: 4]   = e[i].wmask;
                in_mem_rdata[i*32 +: 32] = e[i].rdata;
                in_mem_wdata[i*32 +: 32] = e[i].wdata;
            end else begin
                in_order[i*64 +: 64]     = {$urandom, $urandom};
                in_mem_addr[i*32 +: 32]  = $urandom;
                in_mem_rmask[i*4 +: 4]   = 4'($urandom);
                in_mem_wmask[i*4 +: 4]   = 4'($urandom);
                in_mem_rdata[i*32 +: 32] = $urandom;
                in_mem_wdata[i*32 +: 32] = $urandom;
            end
        end
        exp_e = mk(64'd0);
        exp_v = 1'b0;
        if (!rst_v) begin
            model_clear();
        end else begin
            if (m_q.size() > 0) begin
                exp_v = 1'b1;
                exp_e = m_q.pop_front();
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(e[i]);
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
                        if (m_armed && e[i].order != m_expect) m_oerr = 1'b1;
                        m_armed  = 1'b1;
                        m_expect = e[i].order + 64'd1;
`endif
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            check_eq("out_order", out_order, exp_e.order);
            check_eq("out_addr",  64'(out_mem_addr),  64'(exp_e.addr));
            check_eq("out_rmask", 64'(out_mem_rmask), 64'(exp_e.rmask));
            check_eq("out_wmask", 64'(out_mem_wmask), 64'(exp_e.wmask));
            check_eq("out_rdata", 64'(out_mem_rdata), 64'(exp_e.rdata));
            check_eq("out_wdata", 64'(out_mem_wdata), 64'(exp_e.wdata));
        end else begin
            check_eq("idle_payload", out_order | 64'(out_mem_addr) | 64'(out_mem_rdata)
                     | 64'(out_mem_wdata) | 64'(out_mem_rmask) | 64'(out_mem_wmask), 64'd0);
        end
        check_eq("level",     64'(level),     64'(m_q.size()));
        check_eq("overflow",  64'(overflow),  64'(m_ovf));
        check_eq("order_err", 64'(order_err), 64'(m_oerr));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 2'b00, 64'd0, 64'd0);
    endtask

    initial begin
        // Reset held with traffic on the bus
        for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 64'(k), 64'(k + 50));
        step(1'b1, 2'b01, 64'd100, 64'd0);
        step(1'b1, 2'b00, 64'd0, 64'd0);
        check_eq("first_out_order", out_order, 64'd100);
        idle(2);
        step(1'b1, 2'b10, 64'd0, 64'd101);
        idle(2);

        // In-order burst 10..13
        step(1'b0, 2'b00, 64'd0, 64'd0);
        step(1'b1, 2'b11, 64'd10, 64'd11);
        step(1'b1, 2'b11, 64'd12, 64'd13);
        check_eq("burst_peak_level", 64'(level), 64'd3);
        idle(5);

        // Overflow: sustained dual retirement, then a retirement after the drop
        step(1'b0, 2'b00, 64'd0, 64'd0);
        for (int k = 0; k < 8; k++) step(1'b1, 2'b11, 64'(2*k), 64'(2*k + 1));
        check_eq("overflow_set", 64'(overflow), 64'd1);
        step(1'b1, 2'b01, 64'd16, 64'd0);
        idle(10);

        // Order gap 5,6,8 then 9
        step(1'b0, 2'b00, 64'd0, 64'd0);
        step(1'b1, 2'b01, 64'd5, 64'd0);
        step(1'b1, 2'b01, 64'd6, 64'd0);
        step(1'b1, 2'b01, 64'd8, 64'd0);
        step(1'b1, 2'b01, 64'd9, 64'd0);
        idle(4);

        // Asynchronous reset with six entries buffered
        step(1'b0, 2'b00, 64'd0, 64'd0);
        step(1'b1, 2'b11, 64'd40, 64'd41);
        for (int k = 0; k < 4; k++) step(1'b1, 2'b11, 64'(42 + 2*k), 64'(43 + 2*k));
        check_eq("fill_level", 64'(level), 64'd6);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check_eq("async_valid", 64'(out_valid), 64'd0);
        check_eq("async_level", 64'(level), 64'd0);
        step(1'b0, 2'b11, 64'd60, 64'd61);
        idle(4);
        step(1'b1, 2'b01, 64'd70, 64'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
